lif_array: RTL
==============

Name: lif_array

Overview:
- Parametrised successor to the single leaky integrate-and-fire neuron: N independent LIF neurons sharing one time-multiplexed update datapath.
- Adds a real leak term, saturating arithmetic, a runtime threshold, a selectable reset mode and a refractory period.
- Sits between the input-current front end and the spike encoder/output logic.
- One `step` pulse advances every neuron by one timestep and returns a registered spike vector.

Parameters:
- N_NEURONS, 4, number of neurons (≥1); membrane storage is a register array.
- WIDTH, 8, bit width of currents, membrane potential and threshold.
- LEAK_SHIFT, 1, leak = V >> LEAK_SHIFT per timestep (1..WIDTH-1).
- REFRAC_STEPS, 2, timesteps a neuron is held after spiking (0 = no refractory); counter width = $clog2(REFRAC_STEPS+1), minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- step  input  1  one-cycle pulse that starts a timestep sweep; ignored while busy.
- currents  input  N_NEURONS*WIDTH  packed unsigned input currents; neuron k at bits [k*WIDTH +: WIDTH]; sampled on an accepted step.
- threshold  input  WIDTH  unsigned firing threshold; sampled on an accepted step.
- sub_mode  input  1  0 = reset-to-zero on spike, 1 = subtract threshold on spike; sampled on an accepted step.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse; spikes are valid from this cycle.
- spikes  output  N_NEURONS  spike vector of the last completed timestep; held until the next done.

Behaviour:
- One clock, `clk`; reset is synchronous and active-high.
- Reset:
  - all membrane V[k] = 0, refractory counters = 0.
  - busy = 0, done = 0, spikes = 0.
  - channel index = 0, FSM in IDLE.
  - Reset mid-sweep aborts the sweep; no done pulse follows.
- FSM:
  - IDLE: if step=1, latch currents, threshold and sub_mode; set channel index to 0; go to SWEEP (busy=1 from the next cycle).
  - SWEEP: update neuron[index] this cycle; index += 1. After index N_NEURONS-1, go to DONE.
  - DONE: drive the accumulated spike vector to spikes; done=1 for this cycle; busy=0; return to IDLE.
- Latency:
  - step accepted at cycle t; neuron k is updated at t+1+k.
  - done and spikes are valid at t+N_NEURONS+1.
  - The earliest next accepted step is at the done cycle + 1. A step asserted while busy or during done is dropped, not queued.
- Per-neuron update (unsigned, computed at WIDTH+1 bits):
  - If refrac[k] > 0: refrac[k] -= 1, V[k] stays 0, spike bit = 0, and the input current is ignored.
  - Otherwise:
    - Vn = V - (V >> LEAK_SHIFT) + I.
    - Saturate: if Vn > 2^WIDTH-1, Vn = 2^WIDTH-1.
    - Fire when Vn >= threshold:
      - spike bit = 1.
      - V = 0 if sub_mode=0, else Vn - threshold.
      - refrac[k] = REFRAC_STEPS.
    - Else V = Vn, spike bit = 0.
- Boundary cases:
  - threshold = 0: every non-refractory neuron fires each step, even with V = 0 and I = 0.
  - Subtract mode never underflows, because Vn >= threshold when firing.
  - Saturation is checked before the threshold compare.
  - The spike vector is built in a shadow register during SWEEP. The spikes output changes only on the DONE cycle.

Decomposition:
- Shared package lif_pkg:
  - FSM state enum {IDLE, SWEEP, DONE}.
  - Reset-mode constants MODE_ZERO = 0, MODE_SUB = 1.
- Sub-module lif_update:
  - purely combinational single-neuron datapath.
  - Inputs: V, I, refrac, threshold, mode. Outputs: V_next, refrac_next, spike.
  - Instantiated once in lif_array and shared across all neurons.

Test Plan (N_NEURONS=4, WIDTH=8, LEAK_SHIFT=1, REFRAC_STEPS=2 unless stated):
- Reset: assert reset 2 cycles -> busy=0, done=0, spikes=0000, all V=0. Then step with currents=0, threshold=200 -> done exactly 5 cycles after step, spikes=0000.
- Integrate/fire/refractory, sub_mode=0, threshold=200, ch0 I=150 every step:
  - step1: V=150, no spike.
  - step2: 225 -> spikes[0]=1, V=0.
  - steps 3,4: spikes[0]=0, V=0 (refractory).
  - step5: V=150.
- Subtract mode, sub_mode=1, REFRAC_STEPS=0, threshold=200, ch1 I=150: step2 -> spikes[1]=1, V[1]=25.
- Saturation, threshold=255, REFRAC_STEPS=0, ch2:
  - step1 with I=200: V=200, no spike.
  - step2 with I=255: 200-100+255=355 saturates to 255 -> spikes[2]=1, V=0.
- Channel independence: currents {ch3=255, ch0..2=0}, threshold=200 -> spikes=1000 (only bit 3 set); other V stay 0.
- Protocol:
  - step pulsed during busy -> ignored; exactly one done per accepted step.
  - reset asserted at sweep cycle 2 -> no done pulse; state all 0; next step behaves as after a fresh reset.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron array.
package lif_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } lif_state_e;

  localparam logic MODE_ZERO = 1'b0;
  localparam logic MODE_SUB  = 1'b1;

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron LIF step: leak, integrate, saturate, fire, refractory.
module lif_update
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LEAK_SHIFT   = 1,
  parameter int unsigned REFRAC_STEPS = 2,
  parameter int unsigned RefracW      = clog2_min1(REFRAC_STEPS + 1)
) (
  input  logic [WIDTH-1:0]   v_i,
  input  logic [WIDTH-1:0]   cur_i,
  input  logic [RefracW-1:0] refrac_i,
  input  logic [WIDTH-1:0]   threshold_i,
  input  logic               mode_i,
  output logic [WIDTH-1:0]   v_next_o,
  output logic [RefracW-1:0] refrac_next_o,
  output logic               spike_o
);

  localparam logic [RefracW-1:0] RefracInit = RefracW'(REFRAC_STEPS);

  logic [WIDTH-1:0] leak;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat;

  always_comb begin
    leak = v_i >> LEAK_SHIFT;
    // v_i - leak never goes negative, and adding cur_i fits in WIDTH+1 bits.
    sum  = {1'b0, v_i} - {1'b0, leak} + {1'b0, cur_i};
    sat  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  always_comb begin
    v_next_o      = '0;
    refrac_next_o = '0;
    spike_o       = 1'b0;
    if (refrac_i != '0) begin
      refrac_next_o = refrac_i - 1'b1;
    end else if (sat >= threshold_i) begin
      spike_o       = 1'b1;
      refrac_next_o = RefracInit;
      v_next_o      = (mode_i == MODE_SUB) ? (sat - threshold_i) : '0;
    end else begin
      v_next_o = sat;
    end
  end

endmodule

// File: rtl/lif_array.sv
// N leaky integrate-and-fire neurons sharing one update datapath, swept one neuron per cycle.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N_NEURONS    = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned LEAK_SHIFT   = 1,
  parameter int unsigned REFRAC_STEPS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic [N_NEURONS*WIDTH-1:0] currents,
  input  logic [WIDTH-1:0]           threshold,
  input  logic                       sub_mode,
  output logic                       busy,
  output logic                       done,
  output logic [N_NEURONS-1:0]       spikes
);

  localparam int unsigned RefracW = clog2_min1(REFRAC_STEPS + 1);
  localparam int unsigned IdxW    = clog2_min1(N_NEURONS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_NEURONS - 1);

  lif_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [N_NEURONS*WIDTH-1:0] cur_q;
  logic [WIDTH-1:0]           thr_q;
  logic                       mode_q;

  logic [WIDTH-1:0]   v_q      [N_NEURONS];
  logic [RefracW-1:0] refrac_q [N_NEURONS];

  logic [N_NEURONS-1:0] shadow_q, shadow_d;
  logic [N_NEURONS-1:0] spikes_q;

  logic               accept;
  logic               sweep;
  logic               last;
  logic [WIDTH-1:0]   v_sel;
  logic [WIDTH-1:0]   cur_sel;
  logic [RefracW-1:0] refrac_sel;
  logic [WIDTH-1:0]   v_next;
  logic [RefracW-1:0] refrac_next;
  logic               spike;

  assign sweep = (state_q == StSweep);
  assign last  = sweep && (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (step) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = StSweep;
        end
      end
      StSweep: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign v_sel      = v_q[idx_q];
  assign refrac_sel = refrac_q[idx_q];
  assign cur_sel    = cur_q[idx_q*WIDTH +: WIDTH];

  lif_update #(
    .WIDTH        (WIDTH),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .REFRAC_STEPS (REFRAC_STEPS),
    .RefracW      (RefracW)
  ) u_update (
    .v_i           (v_sel),
    .cur_i         (cur_sel),
    .refrac_i      (refrac_sel),
    .threshold_i   (thr_q),
    .mode_i        (mode_q),
    .v_next_o      (v_next),
    .refrac_next_o (refrac_next),
    .spike_o       (spike)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (accept) begin
      shadow_d = '0;
    end else if (sweep) begin
      shadow_d[idx_q] = spike;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cur_q    <= '0;
      thr_q    <= '0;
      mode_q   <= MODE_ZERO;
      shadow_q <= '0;
      spikes_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      if (accept) begin
        cur_q  <= currents;
        thr_q  <= threshold;
        mode_q <= sub_mode;
      end
      // Publish the full vector so it becomes visible exactly on the done cycle.
      if (last) begin
        spikes_q <= shadow_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_NEURONS; k++) begin
      if (reset) begin
        v_q[k]      <= '0;
        refrac_q[k] <= '0;
      end else if (sweep && (idx_q == IdxW'(k))) begin
        v_q[k]      <= v_next;
        refrac_q[k] <= refrac_next;
      end
    end
  end

  assign busy   = sweep;
  assign done   = (state_q == StDone);
  assign spikes = spikes_q;

endmodule
